spi_slave_rx_mode3: RTL

SPI mode-3 (CPOL=1, CPHA=1) receive stage that sits directly downstream of `test_spi_master_tx_mode3`. It consumes `cs_n`, `sclk` and `mosi` from the master and recovers MSB-first words into the `In_clk` domain. Each completed word is presented with a one-cycle valid strobe, and a frame aborted mid-word is flagged. The block oversamples the SPI lines with the system clock; there is no SCLK-domain logic.

---
 rtl/spi_slave_rx_mode3.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 (CPOL=1, CPHA=1) receiver that oversamples cs_n/sclk/mosi with In_clk
// and recovers MSB-first words, flagging frames that end with a partial word.
module spi_slave_rx_mode3 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  In_clk,
  input  logic                  In_rst_n,
  input  logic                  In_spi_cs_n,
  input  logic                  In_spi_sclk,
  input  logic                  In_spi_mosi,
  output logic [DATA_WIDTH-1:0] Out_rx_data,
  output logic                  Out_rx_valid,
  output logic                  Out_frame_err,
  output logic                  Out_busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchroniser chains: metastability flop, sync flop, then history for edge detect.
  logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
  logic cs_meta_q,   cs_sync_q,   cs_hist_q;
  logic mosi_meta_q, mosi_sync_q;

  logic sclk_rise, cs_fall, cs_rise;

  logic [0:0]            state_q,     state_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  frame_err_q, frame_err_d;

  // cs_n resets low so a chip select held low across reset release is not seen as a fall.
  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      sclk_meta_q <= 1'b1;
      sclk_sync_q <= 1'b1;
      sclk_hist_q <= 1'b1;
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_hist_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of its
      // predecessor, which is what makes this a shift chain rather than a wire.
      sclk_meta_q <= In_spi_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_hist_q <= sclk_sync_q;
      cs_meta_q   <= In_spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_hist_q   <= cs_sync_q;
      mosi_meta_q <= In_spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise = ~sclk_hist_q &  sclk_sync_q;
  assign cs_fall   =  cs_hist_q   & ~cs_sync_q;
  assign cs_rise   = ~cs_hist_q   &  cs_sync_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (sclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], mosi_sync_q};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        // Judging the post-shift count lets a final bit coincident with cs_n rising complete cleanly.
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (bit_cnt_d != '0) begin
            frame_err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Out_rx_data   = rx_data_q;
  assign Out_rx_valid  = rx_valid_q;
  assign Out_frame_err = frame_err_q;
  assign Out_busy      = (state_q == ST_ACTIVE);

endmodule
